// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int PC_STEP = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel plus the decode-side handshake.
interface fetch_if #(parameter int D_WIDTH = 32);
    logic               imem_req_valid;
    logic [D_WIDTH-1:0] imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [D_WIDTH-1:0] imem_rsp_data;
    logic               inst_valid;
    logic [D_WIDTH-1:0] inst;
    logic [D_WIDTH-1:0] prog_addr;
    logic               inst_ready;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, prog_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, prog_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap freely.
module fetch_queue #(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_pkg::fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited sequential requests,
// and queues returned instructions for decode; redirects flush and drop stale responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 D_WIDTH  = XLEN,
    parameter logic [D_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                 DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pcsrc,
    input  logic [D_WIDTH-1:0] jumpaddress,
    fetch_if.master            bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [D_WIDTH-1:0] pc;
        logic [D_WIDTH-1:0] inst;
    } entry_t;

    logic [D_WIDTH-1:0] fetch_pc;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      drop;
    logic [CW-1:0]      q_count;
    logic [CW-1:0]      pc_count;
    logic [CW:0]        credit_used;
    logic               started;
    logic               req_fire;
    logic               rsp_ok;
    logic               q_push;
    logic               q_pop;
    logic               q_full;
    logic               q_empty;
    logic               pc_full;
    logic               pc_empty;
    entry_t             q_in;
    entry_t             q_head;
    entry_t             pc_in;
    entry_t             pc_head;
    logic               unused_ok;

    // Queue occupancy plus outstanding requests can never exceed DEPTH, so
    // neither FIFO can overflow and a response always has a slot.
    assign credit_used        = {1'b0, q_count} + {1'b0, inflight};
    assign bus.imem_req_valid = started && !pcsrc && (credit_used < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_ok   = bus.imem_rsp_valid && (inflight != '0);
    assign q_push   = rsp_ok && !pcsrc && (drop == '0);
    assign q_pop    = bus.inst_valid && bus.inst_ready && !pcsrc;

    always_comb begin
        pc_in      = '0;
        pc_in.pc   = fetch_pc;
        q_in       = '0;
        q_in.pc    = pc_head.pc;
        q_in.inst  = bus.imem_rsp_data;
    end

    assign bus.inst_valid = !q_empty;
    assign bus.inst       = q_head.inst;
    assign bus.prog_addr  = q_head.pc;

    // started holds request-valid low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            started <= 1'b1;
            if (pcsrc)         fetch_pc <= {jumpaddress[D_WIDTH-1:2], 2'b00};
            else if (req_fire) fetch_pc <= fetch_pc + D_WIDTH'(PC_STEP);
            inflight <= inflight + CW'(req_fire) - CW'(rsp_ok);
            if (pcsrc)                       drop <= inflight - CW'(rsp_ok);
            else if (rsp_ok && drop != '0)   drop <= drop - CW'(1);
        end
    end

    fetch_queue #(.DEPTH(DEPTH), .T(entry_t)) u_pc_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc_in),
        .pop       (rsp_ok),
        .head      (pc_head),
        .count     (pc_count),
        .full      (pc_full),
        .empty     (pc_empty)
    );

    fetch_queue #(.DEPTH(DEPTH), .T(entry_t)) u_inst_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (pcsrc),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign unused_ok = &{1'b0, pc_head.inst, pc_count, pc_full, pc_empty, q_full};

    // A response with nothing outstanding is a memory protocol violation.
    a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rsp_valid && inflight == '0));
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench: expected stream is the sequential PC walk from the last redirect.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          W     = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] jumpaddress = '0;

    fetch_if #(.D_WIDTH(W)) bus ();

    fetch_unit #(.D_WIDTH(W), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcsrc       (pcsrc),
        .jumpaddress (jumpaddress),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ndel = 0;
    int          first_del_cyc = -1;
    int          req_count = 0;
    int          last_due = -1;
    int          p_req_ready, p_inst_ready, lat_min, lat_max;
    logic [31:0] exp_q[$];
    mreq_t       mq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_stream(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(base + 32'(4 * i));
    endfunction

    // One clock: drive this cycle's inputs after the edge, sample at the falling edge.
    task automatic tick(input bit redir, input logic [31:0] tgt);
        mreq_t m;
        int    due;
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(m.addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        bus.imem_req_ready = ($urandom_range(99, 0) < p_req_ready);
        bus.inst_ready     = ($urandom_range(99, 0) < p_inst_ready);
        pcsrc       = redir;
        jumpaddress = tgt;
        if (redir) push_stream(tgt & 32'hFFFF_FFFC);
        @(negedge clk);
        if (redir) check("no_req_on_redirect", 32'(bus.imem_req_valid), 32'd0);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            req_count++;
            check("addr_align", bus.imem_req_addr & 32'h3, 32'h0);
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            m.addr = bus.imem_req_addr;
            m.due  = due;
            mq.push_back(m);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pcsrc = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_prog_addr", bus.prog_addr, 32'd0);
        mq.delete();
        last_due = -1;
        push_stream(RPC);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("valid_before_first_edge", 32'(bus.imem_req_valid), 32'd0);
        cyc = -1;
        first_del_cyc = -1;
    endtask

    // Monitor: pops the scoreboard on every accepted decode transfer.
    initial begin
        logic        hold_vld;
        logic [31:0] hold_inst, hold_pc, e;
        hold_vld = 1'b0;
        hold_inst = '0;
        hold_pc = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_vld = 1'b0;
                continue;
            end
            if (hold_vld) begin
                check("hold_valid", 32'(bus.inst_valid), 32'd1);
                check("hold_inst", bus.inst, hold_inst);
                check("hold_prog_addr", bus.prog_addr, hold_pc);
            end
            hold_vld  = bus.inst_valid && !bus.inst_ready && !pcsrc;
            hold_inst = bus.inst;
            hold_pc   = bus.prog_addr;
            if (bus.inst_valid && bus.inst_ready && !pcsrc) begin
                e = exp_q.pop_front();
                check("prog_addr", bus.prog_addr, e);
                check("inst", bus.inst, mem_word(e));
                exp_q.push_back(exp_q[$] + 32'd4);
                ndel++;
                if (first_del_cyc < 0) first_del_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;

        // Streaming with 1-cycle memory: first delivery at cycle 2, then one per cycle.
        p_req_ready = 100; p_inst_ready = 100; lat_min = 1; lat_max = 1;
        do_reset();
        ndel = 0;
        repeat (22) tick(1'b0, '0);
        check("first_delivery_cycle", first_del_cyc, 32'd2);
        check("throughput", ndel, 32'd20);

        // Decode stalled: credit allows exactly DEPTH requests.
        do_reset();
        p_inst_ready = 0;
        req_count = 0;
        repeat (10) tick(1'b0, '0);
        check("stall_req_count", req_count, DEPTH);
        check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("stall_head_valid", 32'(bus.inst_valid), 32'd1);
        check("stall_head_pc", bus.prog_addr, RPC);
        p_inst_ready = 100;
        repeat (10) tick(1'b0, '0);

        // Redirect with two requests outstanding on a 3-cycle memory.
        do_reset();
        lat_min = 3; lat_max = 3;
        tick(1'b0, '0);
        tick(1'b0, '0);
        tick(1'b1, 32'h100);
        tick(1'b0, '0);
        check("redir_valid", 32'(bus.imem_req_valid), 32'd1);
        check("redir_addr", bus.imem_req_addr, 32'h100);
        lat_min = 1; lat_max = 1;
        repeat (8) tick(1'b0, '0);

        // Unaligned target.
        tick(1'b1, 32'h203);
        tick(1'b0, '0);
        check("unaligned_valid", 32'(bus.imem_req_valid), 32'd1);
        check("unaligned_addr", bus.imem_req_addr, 32'h200);
        repeat (8) tick(1'b0, '0);

        // Redirect coinciding with a response and a decode pop.
        tick(1'b1, 32'h400);
        check("collide_pop_present", 32'(bus.inst_valid), 32'd1);
        tick(1'b0, '0);
        check("collide_flushed", 32'(bus.inst_valid), 32'd0);
        repeat (8) tick(1'b0, '0);

        // PC wrap at the top of the address space.
        tick(1'b1, 32'hFFFF_FFFC);
        tick(1'b0, '0);
        check("wrap_addr_hi", bus.imem_req_addr, 32'hFFFF_FFFC);
        tick(1'b0, '0);
        check("wrap_valid", 32'(bus.imem_req_valid), 32'd1);
        check("wrap_addr_lo", bus.imem_req_addr, 32'h0);
        repeat (8) tick(1'b0, '0);

        // Random traffic with random redirects.
        d0 = ndel;
        p_req_ready = 70; p_inst_ready = 60; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(99, 0) < 3, $urandom());

        // Reset mid-stream, then restart.
        do_reset();
        p_req_ready = 100;
        tick(1'b0, '0);
        check("restart_valid", 32'(bus.imem_req_valid), 32'd1);
        check("restart_addr", bus.imem_req_addr, RPC);
        p_req_ready = 70;
        for (int i = 0; i < 500; i++)
            tick($urandom_range(99, 0) < 3, $urandom());
        check("liveness", 32'(ndel - d0 > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
